// File: rtl/pcs_pkg.sv
// Shared PCS receive definitions: sync-header codes, block-lock thresholds,
// descrambler tap positions and the lock-state encoding.
package pcs_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int LOCK_GOOD_CNT = 64;
  localparam int LOCK_BAD_CNT  = 16;

  // 1 + x^39 + x^58: taps sit 39 and 58 bits behind the current bit
  localparam int SCR_LEN = 58;
  localparam int SCR_TAP = SCR_LEN - 39;

  typedef enum logic [1:0] {
    LS_UNLOCKED = 2'd0,
    LS_SLIP     = 2'd1,
    LS_LOCKED   = 2'd2
  } lock_state_e;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Block-lock hunt state machine: counts sync-header events, requests gearbox slips.
// Optional invalid-header counter enabled by PCS_RX_ERR_CNT_EN.
module block_lock_fsm
  import pcs_pkg::*;
#(
  parameter int SLIP_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hdr_event_i,
  input  logic        hdr_valid_i,
`ifdef PCS_RX_ERR_CNT_EN
  output logic [15:0] err_count_o,
`endif
  output logic        block_lock_o,
  output logic        slip_o
);

  localparam int SW   = (SLIP_WAIT < 1) ? 1 : SLIP_WAIT;
  localparam int SW_W = $clog2(SW + 1);
  localparam logic [SW_W-1:0] WAIT_LAST = SW_W'(SW - 1);
  localparam logic [6:0] GOOD_TH = 7'(LOCK_GOOD_CNT);
  localparam logic [4:0] BAD_TH  = 5'(LOCK_BAD_CNT);

  lock_state_e     state_q, state_d;
  logic [6:0]      sh_cnt_q, sh_cnt_d, sh_inc_s;
  logic [4:0]      bad_cnt_q, bad_cnt_d, bad_inc_s;
  logic [SW_W-1:0] wait_q, wait_d;
  logic            slip_q, slip_d;
  logic            lock_q, lock_d;

  assign sh_inc_s  = sh_cnt_q + 7'd1;
  assign bad_inc_s = bad_cnt_q + {4'd0, ~hdr_valid_i};

  // next-state, counter and slip-request decode
  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    bad_cnt_d = bad_cnt_q;
    wait_d    = wait_q;
    slip_d    = 1'b0;
    case (state_q)
      LS_UNLOCKED: begin
        if (hdr_event_i) begin
          if (!hdr_valid_i) begin
            slip_d    = 1'b1;
            state_d   = LS_SLIP;
            wait_d    = {SW_W{1'b0}};
            sh_cnt_d  = 7'd0;
            bad_cnt_d = 5'd0;
          end else if (sh_inc_s == GOOD_TH) begin
            state_d   = LS_LOCKED;
            sh_cnt_d  = 7'd0;
            bad_cnt_d = 5'd0;
          end else begin
            sh_cnt_d  = sh_inc_s;
          end
        end else begin
          sh_cnt_d = sh_cnt_q;
        end
      end
      LS_SLIP: begin
        // headers are ignored while the gearbox settles after the slip
        if (wait_q == WAIT_LAST) begin
          state_d   = LS_UNLOCKED;
          wait_d    = {SW_W{1'b0}};
          sh_cnt_d  = 7'd0;
          bad_cnt_d = 5'd0;
        end else begin
          wait_d = wait_q + {{(SW_W-1){1'b0}}, 1'b1};
        end
      end
      LS_LOCKED: begin
        if (hdr_event_i) begin
          if (bad_inc_s == BAD_TH) begin
            slip_d    = 1'b1;
            state_d   = LS_SLIP;
            wait_d    = {SW_W{1'b0}};
            sh_cnt_d  = 7'd0;
            bad_cnt_d = 5'd0;
          end else if (sh_inc_s == GOOD_TH) begin
            sh_cnt_d  = 7'd0;
            bad_cnt_d = 5'd0;
          end else begin
            sh_cnt_d  = sh_inc_s;
            bad_cnt_d = bad_inc_s;
          end
        end else begin
          sh_cnt_d = sh_cnt_q;
        end
      end
      default: begin
        state_d   = LS_UNLOCKED;
        wait_d    = {SW_W{1'b0}};
        sh_cnt_d  = 7'd0;
        bad_cnt_d = 5'd0;
      end
    endcase
    lock_d = (state_d == LS_LOCKED);
  end

  // state, counters and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= LS_UNLOCKED;
      sh_cnt_q  <= 7'd0;
      bad_cnt_q <= 5'd0;
      wait_q    <= {SW_W{1'b0}};
      slip_q    <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      bad_cnt_q <= bad_cnt_d;
      wait_q    <= wait_d;
      slip_q    <= slip_d;
      lock_q    <= lock_d;
    end
  end

  assign block_lock_o = lock_q;
  assign slip_o       = slip_q;

`ifdef PCS_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // saturating count of bad headers seen outside the slip window
  always_comb begin
    if (hdr_event_i && !hdr_valid_i && (state_q != LS_SLIP) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // error counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: rtl/descrambler.sv
// 10GBASE-R self-synchronising descrambler (1 + x^39 + x^58) with block lock.
// Define PCS_RX_ERR_CNT_EN to add the o_err_count invalid-header counter.
module descrambler
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SLIP_WAIT  = 4
) (
  input  logic                  i_rxc,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rxd,
  input  logic [1:0]            i_rx_header,
  input  logic                  i_rx_header_valid,
  input  logic                  i_rx_pause,
  output logic [DATA_WIDTH-1:0] o_rxd,
  output logic [1:0]            o_rx_header,
  output logic                  o_rx_header_valid,
  output logic                  o_rx_valid,
`ifdef PCS_RX_ERR_CNT_EN
  output logic [15:0]           o_err_count,
`endif
  output logic                  o_block_lock,
  output logic                  o_slip
);

  logic [SCR_LEN-1:0]            hist_q, hist_d;
  logic [DATA_WIDTH+SCR_LEN-1:0] v_s;
  logic [DATA_WIDTH-1:0]         rxd_d, rxd_q;
  logic [1:0]                    hdr_q;
  logic                          hv_q, vld_q;
  logic                          hdr_event_s, hdr_ok_s;

  // descramble against the history of received scrambled bits
  always_comb begin
    v_s   = {i_rxd, hist_q};
    rxd_d = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rxd_d[i] = v_s[SCR_LEN+i] ^ v_s[SCR_TAP+i] ^ v_s[i];
    end
    if (!i_rx_pause) begin
      hist_d = v_s[DATA_WIDTH +: SCR_LEN];
    end else begin
      hist_d = hist_q;
    end
  end

  // one-cycle datapath registers
  always_ff @(posedge i_rxc or posedge i_reset) begin
    if (i_reset) begin
      hist_q <= {SCR_LEN{1'b0}};
      rxd_q  <= {DATA_WIDTH{1'b0}};
      hdr_q  <= 2'b00;
      hv_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      rxd_q  <= rxd_d;
      hdr_q  <= i_rx_header;
      hv_q   <= i_rx_header_valid;
      vld_q  <= ~i_rx_pause;
    end
  end

  assign o_rxd             = rxd_q;
  assign o_rx_header       = hdr_q;
  assign o_rx_header_valid = hv_q;
  assign o_rx_valid        = vld_q;

  assign hdr_event_s = i_rx_header_valid & ~i_rx_pause;
  assign hdr_ok_s    = sh_is_valid(i_rx_header);

  block_lock_fsm #(
    .SLIP_WAIT(SLIP_WAIT)
  ) u_lock (
    .clk_i       (i_rxc),
    .rst_i       (i_reset),
    .hdr_event_i (hdr_event_s),
    .hdr_valid_i (hdr_ok_s),
`ifdef PCS_RX_ERR_CNT_EN
    .err_count_o (o_err_count),
`endif
    .block_lock_o(o_block_lock),
    .slip_o      (o_slip)
  );

endmodule

// File: doc/descrambler.md
# descrambler

Receive-side counterpart of the PCS transmit scrambler. It is the 10GBASE-R self-synchronising descrambler for the 1 + x^39 + x^58 polynomial, with the Clause-49-style block-lock state machine built in. It sits between the RX gearbox and the 64b/66b decoder. It consumes scrambled payload words plus sync headers, emits descrambled words and reports lock. It drives a one-cycle slip request back to the gearbox while hunting for block alignment.

## Interface
- DATA_WIDTH, 32, payload word width; legal values 32 or 64.
- SLIP_WAIT, 4, cycles to ignore headers after a slip pulse (gearbox settle time).
- i_rxc  in  1  RX clock; all logic on rising edge.
- i_reset  in  1  reset, asynchronous and active-high.
- i_rxd  in  DATA_WIDTH  scrambled payload, bit 0 received first.
- i_rx_header  in  2  sync header of the current block.
- i_rx_header_valid  in  1  current word is the first word of a block (i_rx_header meaningful).
- i_rx_pause  in  1  gearbox pause; word invalid this cycle.
- o_rxd  out  DATA_WIDTH  descrambled payload.
- o_rx_header  out  2  header aligned with o_rxd.
- o_rx_header_valid  out  1  o_rxd is the first word of a block.
- o_rx_valid  out  1  o_rxd valid (not a paused cycle).
- o_block_lock  out  1  block lock acquired.
- o_slip  out  1  one-cycle request to the gearbox to slip one bit.

## Operation
- Descrambling: 58-bit history register of previously received scrambled bits, reset to 0. Form v = {i_rxd, hist}.
  - o_rxd[i] = v[58+i] ^ v[19+i] ^ v[i].
  - On a non-paused cycle, hist <= v[DATA_WIDTH +: 58].
  - Paused cycles leave hist untouched.
  - The first 58 output bits after reset are garbage by construction; the block does not mask them.
- Headers are not scrambled and are passed through unchanged.
- A header is valid when i_rx_header is 2'b01 or 2'b10. Only words with i_rx_header_valid=1 and i_rx_pause=0 are header events. In 64-bit mode every unpaused word is a block start. In 32-bit mode the upstream gearbox supplies the alternation; this block does not enforce it.
- Lock FSM states:
  - UNLOCKED: sh_cnt and bad_cnt are cleared on entry.
    - Valid header -> sh_cnt++.
    - sh_cnt reaching 64 -> LOCKED, counters cleared.
    - Invalid header -> o_slip pulse, go to SLIP.
  - SLIP: counts SLIP_WAIT cycles, ignoring header events, then -> UNLOCKED.
  - LOCKED: every header event -> sh_cnt++; invalid header -> bad_cnt++.
    - bad_cnt reaching 16 -> o_slip pulse, lock dropped, go to SLIP.
    - Else sh_cnt reaching 64 -> both counters cleared, stay LOCKED.
    - If both thresholds are hit on the same event, loss of lock wins.
- o_block_lock = (state == LOCKED), registered.
- Data is passed whether or not lock is held; the downstream block qualifies it with o_block_lock.
- sh_cnt is 7 bits and bad_cnt is 5 bits. Neither wraps, because both are cleared at threshold.

## Timing
- Reset values of all outputs, hist, counters and state are 0 / UNLOCKED. Asserting reset mid-operation drops lock immediately, asynchronously.
- Data path latency is 1 cycle. o_rxd, o_rx_header, o_rx_header_valid and o_rx_valid are registered from the cycle-N inputs. o_rx_valid = !i_rx_pause delayed by one cycle.
- o_slip is high for exactly one cycle, in the cycle after the offending header. It never asserts on two consecutive cycles. It is never asserted in LOCKED except on the loss-of-lock event.
- o_block_lock rises in the cycle after the 64th consecutive valid header. It falls in the cycle after the 16th bad header.
- A pause coinciding with i_rx_header_valid suppresses the header event entirely.

## Configuration
- PCS_RX_ERR_CNT_EN defined: adds output o_err_count[15:0].
  - Counts every invalid-header event in any state except SLIP.
  - Saturates at 16'hFFFF and resets to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared pcs_pkg holds:
  - Header constants SH_DATA=2'b01 and SH_CTRL=2'b10.
  - Lock thresholds LOCK_GOOD_CNT=64 and LOCK_BAD_CNT=16.
  - The lock-state enum.
- One sub-module, block_lock_fsm: the header events, counters, state and o_slip. It is reused by the RX gearbox bench.
- The descrambler datapath stays in the top.

## Test plan
- Scrambler loopback:
  - Stimulus: feed the transmit scrambler output (DATA_WIDTH 32 and 64) of an incrementing payload with valid headers.
  - Response: after the first 58 bits, o_rxd equals the original payload exactly, latency 1.
- Lock acquire:
  - Stimulus: 64 valid headers.
  - Response: o_block_lock=1 one cycle after the 64th header; o_slip never asserted.
- Hunt:
  - Stimulus: header 2'b00 while UNLOCKED.
  - Response: one o_slip pulse; the next SLIP_WAIT=4 cycles of headers are ignored; the count restarts.
- Lock loss:
  - Stimulus: in LOCKED, 15 bad headers within 64 events.
  - Response: lock holds; a 16th bad header gives o_block_lock=0 and an o_slip pulse. A 64th event with 15 bad headers clears the counters.
- Pause:
  - Stimulus: i_rx_pause every 33rd cycle.
  - Response: o_rx_valid low the following cycle; descrambled data stays correct; the lock count is unaffected.
- Reset:
  - Stimulus: assert i_reset while locked.
  - Response: all outputs 0 immediately. With PCS_RX_ERR_CNT_EN, o_err_count=0 and it saturates after 65535 bad headers.
